// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates pipeline writeback against
// buffered mul/div results and stalls decode on hazards against them.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   wb_valid/rd/data    pipeline writeback request
//   wb_hold             pipeline must hold its WB stage this cycle
//   md_issue/issue_rd   decode issued a mul/div op targeting issue_rd
//   md_valid/rd/data    mul/div result handshake (md_ready = FIFO not full)
//   dec_rs1/rs2/rd      decode operands checked against the busy scoreboard
//   dec_stall           decode hazard against an outstanding mul/div rd
//   RegWrite/Rd/...     registered write port to Reg_File
module regfile_wb_scheduler #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            wb_hold,
  input  logic            md_issue,
  input  logic [4:0]      md_issue_rd,
  input  logic            md_valid,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_data,
  output logic            md_ready,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  output logic            dec_stall,
  output logic            RegWrite,
  output logic [4:0]      Rd,
  output logic [XLEN-1:0] Write_data
);

  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

  logic [4:0]      q_rd   [2];
  logic [XLEN-1:0] q_data [2];
  logic            head;
  logic            tail;
  logic [1:0]      count;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            wb_req;
  logic            grant_wb;
  logic            starve_fire;
  logic [SW-1:0]   starve;
  logic [31:0]     busy;
  logic [31:0]     busy_set;
  logic [31:0]     busy_clr;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);
  assign md_ready  = !full;
  // rd==0 results complete the handshake but are never buffered
  assign push      = md_valid && !full && (md_rd != 5'd0);
  assign wb_req    = wb_valid && (wb_rd != 5'd0);
  assign head_rd   = q_rd[head];
  assign head_data = q_data[head];

  always_comb begin
    pop      = 1'b0;
    grant_wb = 1'b0;
    if (wb_hold) begin
      pop = !empty;
    end else if (wb_req) begin
      grant_wb = 1'b1;
    end else begin
      pop = !empty;
    end
  end

  assign starve_fire = !empty && !pop && (starve == STARVE_MAX);

  // set is ORed after clear so a same-cycle reissue keeps the bit
  assign busy_set = (md_issue && md_issue_rd != 5'd0)
                    ? (32'd1 << md_issue_rd) : 32'd0;
  assign busy_clr = pop ? (32'd1 << head_rd) : 32'd0;

  assign dec_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= md_rd;
      q_data[tail] <= md_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= 1'b0;
      tail       <= 1'b0;
      count      <= 2'd0;
      starve     <= '0;
      wb_hold    <= 1'b0;
      busy       <= 32'd0;
      RegWrite   <= 1'b0;
      Rd         <= 5'd0;
      Write_data <= '0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (empty || pop || starve_fire) starve <= '0;
      else starve <= starve + SW'(1);
      wb_hold  <= starve_fire;
      busy     <= ((busy & ~busy_clr) | busy_set) & ~32'd1;
      RegWrite <= grant_wb | pop;
      if (grant_wb) begin
        Rd         <= wb_rd;
        Write_data <= wb_data;
      end else if (pop) begin
        Rd         <= head_rd;
        Write_data <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed table-driven bench for regfile_wb_scheduler.
// Each row: inputs for one cycle and the outputs expected during it.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_hold;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_hold(wb_hold),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
    .md_ready(md_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_stall(dec_stall),
    .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data)
  );

  typedef struct {
    logic        rst;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        mi;
    logic [4:0]  mird;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  drd;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_hold;
    logic        e_rdy;
    logic        e_stall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic rst, input logic wv, input logic [4:0] wrd,
    input logic [31:0] wd, input logic mi, input logic [4:0] mird,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] drd,
    input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_wd,
    input logic e_hold, input logic e_rdy, input logic e_stall);
    vec_t r;
    r.rst = rst; r.wv = wv; r.wrd = wrd; r.wd = wd;
    r.mi = mi; r.mird = mird; r.mv = mv; r.mrd = mrd; r.md = md;
    r.rs1 = rs1; r.rs2 = rs2; r.drd = drd;
    r.e_we = e_we; r.e_rd = e_rd; r.e_wd = e_wd;
    r.e_hold = e_hold; r.e_rdy = e_rdy; r.e_stall = e_stall;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    reset       = r.rst;
    wb_valid    = r.wv;
    wb_rd       = r.wrd;
    wb_data     = r.wd;
    md_issue    = r.mi;
    md_issue_rd = r.mird;
    md_valid    = r.mv;
    md_rd       = r.mrd;
    md_data     = r.md;
    dec_rs1     = r.rs1;
    dec_rs2     = r.rs2;
    dec_rd      = r.drd;
  endtask

  task automatic check_row(input int i, input vec_t r);
    chk($sformatf("row%0d RegWrite", i), 32'(RegWrite), 32'(r.e_we));
    chk($sformatf("row%0d Rd", i), 32'(Rd), 32'(r.e_rd));
    chk($sformatf("row%0d Write_data", i), Write_data, r.e_wd);
    chk($sformatf("row%0d wb_hold", i), 32'(wb_hold), 32'(r.e_hold));
    chk($sformatf("row%0d md_ready", i), 32'(md_ready), 32'(r.e_rdy));
    chk($sformatf("row%0d dec_stall", i), 32'(dec_stall), 32'(r.e_stall));
  endtask

  localparam logic [31:0] W  = 32'hDEADBEEF;
  localparam logic [31:0] A5 = 32'hAAAA5555;

  initial begin
    vec_t idle;
    idle = v(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0);
    drive(idle);
    reset = 1'b1;

    // single pipeline write, then rd==0 write consumes nothing
    tbl.push_back(v(0,1,5,W,        0,0, 0,0,0,  0,0,0,  0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  1,5,W,0,1,0));
    tbl.push_back(v(0,1,0,32'hFFFFFFFF,0,0,0,0,0,0,0,0,  0,5,W,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  0,5,W,0,1,0));
    // issue rd10, result 3 cycles later, pipeline idle
    tbl.push_back(v(0,0,0,0,        1,10,0,0,0,  10,0,0, 0,5,W,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  10,0,0, 0,5,W,0,1,1));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  10,0,0, 0,5,W,0,1,1));
    tbl.push_back(v(0,0,0,0,        0,0, 1,10,A5,10,0,0, 0,5,W,0,1,1));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  10,0,0, 0,5,W,0,1,1));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  10,0,0, 1,10,A5,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  0,10,A5,0,1,0));
    // two results under continuous pipeline traffic -> starvation hold
    tbl.push_back(v(0,0,0,0,        1,10,0,0,0,  10,15,0,0,10,A5,0,1,0));
    tbl.push_back(v(0,0,0,0,        1,15,0,0,0,  10,15,0,0,10,A5,0,1,1));
    tbl.push_back(v(0,1,3,32'h33,   0,0, 1,10,32'h1010,10,15,0,0,10,A5,0,1,1));
    tbl.push_back(v(0,1,3,32'h33,   0,0, 1,15,32'h1515,10,15,0,1,3,32'h33,0,1,1));
    tbl.push_back(v(0,1,3,32'h33,   0,0, 0,0,0,  10,15,0,1,3,32'h33,0,0,1));
    tbl.push_back(v(0,1,3,32'h33,   0,0, 0,0,0,  10,15,0,1,3,32'h33,0,0,1));
    tbl.push_back(v(0,1,3,32'h33,   0,0, 0,0,0,  10,15,0,1,3,32'h33,0,0,1));
    tbl.push_back(v(0,1,3,32'h33,   0,0, 0,0,0,  10,15,0,1,3,32'h33,1,0,1));
    tbl.push_back(v(0,1,3,32'h33,   0,0, 0,0,0,  10,0,0, 1,10,32'h1010,0,1,0));
    tbl.push_back(v(0,1,3,32'h33,   0,0, 0,0,0,  0,0,15, 1,3,32'h33,0,1,1));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,15, 1,3,32'h33,0,1,1));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,15, 1,15,32'h1515,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  0,15,32'h1515,0,1,0));
    // full FIFO + pop + md_valid: push refused, accepted next cycle
    tbl.push_back(v(0,1,4,32'h44,   0,0, 1,20,32'h2020,0,0,0,0,15,32'h1515,0,1,0));
    tbl.push_back(v(0,1,4,32'h44,   0,0, 1,21,32'h2121,0,0,0,1,4,32'h44,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 1,22,32'h2222,0,0,0,1,4,32'h44,0,0,0));
    tbl.push_back(v(0,0,0,0,        0,0, 1,22,32'h2222,0,0,0,1,20,32'h2020,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  1,21,32'h2121,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  1,22,32'h2222,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  0,22,32'h2222,0,1,0));
    // md_rd==0 result is dropped
    tbl.push_back(v(0,0,0,0,        0,0, 1,0,32'h0BAD,0,0,0,0,22,32'h2222,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  0,22,32'h2222,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  0,22,32'h2222,0,1,0));
    // reset with two buffered results and busy[10]/busy[15]
    tbl.push_back(v(0,1,6,32'h66,   1,10,0,0,0,  0,0,0,  0,22,32'h2222,0,1,0));
    tbl.push_back(v(0,1,6,32'h66,   1,15,1,10,32'hA0A0,0,0,0,1,6,32'h66,0,1,0));
    tbl.push_back(v(0,1,6,32'h66,   0,0, 1,15,32'hF0F0,10,0,0,1,6,32'h66,0,1,1));
    tbl.push_back(v(1,1,6,32'h66,   0,0, 0,0,0,  10,15,0,1,6,32'h66,0,0,1));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  10,15,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  10,15,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,        0,0, 0,0,0,  0,0,0,  0,0,0,0,1,0));

    @(negedge clk);
    #1;
    chk("reset RegWrite", 32'(RegWrite), 32'd0);
    chk("reset Rd", 32'(Rd), 32'd0);
    chk("reset Write_data", Write_data, 32'd0);
    chk("reset wb_hold", 32'(wb_hold), 32'd0);
    chk("reset md_ready", 32'(md_ready), 32'd1);
    chk("reset dec_stall", 32'(dec_stall), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_row(i, tbl[i]);
    end

    // same-cycle busy set and clear of rd9: set wins
    @(negedge clk);
    drive(idle);
    md_issue = 1'b1; md_issue_rd = 5'd9; dec_rd = 5'd9;
    #1;
    chk("sw0 dec_stall", 32'(dec_stall), 32'd0);
    @(negedge clk);
    drive(idle);
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99; dec_rd = 5'd9;
    #1;
    chk("sw1 dec_stall", 32'(dec_stall), 32'd1);
    @(negedge clk);
    drive(idle);
    md_issue = 1'b1; md_issue_rd = 5'd9; dec_rd = 5'd9;
    #1;
    chk("sw2 RegWrite", 32'(RegWrite), 32'd0);
    chk("sw2 dec_stall", 32'(dec_stall), 32'd1);
    @(negedge clk);
    drive(idle);
    dec_rd = 5'd9;
    #1;
    chk("sw3 RegWrite", 32'(RegWrite), 32'd1);
    chk("sw3 Rd", 32'(Rd), 32'd9);
    chk("sw3 Write_data", Write_data, 32'h99);
    chk("sw3 dec_stall", 32'(dec_stall), 32'd1);
    @(negedge clk);
    drive(idle);
    dec_rd = 5'd9;
    #1;
    chk("sw4 RegWrite", 32'(RegWrite), 32'd0);
    chk("sw4 Rd", 32'(Rd), 32'd9);
    chk("sw4 dec_stall", 32'(dec_stall), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
